// File: rtl/v_ram_pkg.sv
// Shared types and constants for the v_ram reader and its skid FIFO.
// Optional feature macro used by the reader: V_RAM_READER_STRIDE_EN.
package v_ram_pkg;

    localparam int V_RAM_D_WIDTH     = 16;
    localparam int V_RAM_A_WIDTH     = 4;
    localparam int READER_FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } reader_state_t;

endpackage

// File: rtl/v_ram_skid_fifo.sv
// Two-entry FIFO of {last, data} that absorbs RAM words while the consumer stalls.
// Entries reset to zero so the head reads as zero out of reset.
module v_ram_skid_fifo
    import v_ram_pkg::*;
#(
    parameter int D_WIDTH = V_RAM_D_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_i,
    input  logic [D_WIDTH-1:0] push_data_i,
    input  logic               push_last_i,
    input  logic               pop_i,
    output logic [D_WIDTH-1:0] head_data_o,
    output logic               head_last_o,
    output logic [1:0]         occ_o,
    output logic               empty_o
);

    logic [D_WIDTH-1:0] data_q [READER_FIFO_DEPTH];
    logic               last_q [READER_FIFO_DEPTH];
    logic               wr_ptr_q;
    logic               rd_ptr_q;
    logic [1:0]         occ_q;
    logic [1:0]         occ_d;

    always_comb begin
        occ_d = occ_q;
        case ({push_i, pop_i})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < READER_FIFO_DEPTH; i++) begin
                data_q[i] <= '0;
                last_q[i] <= 1'b0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push_i) begin
                data_q[wr_ptr_q] <= push_data_i;
                last_q[wr_ptr_q] <= push_last_i;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= occ_d;
        end
    end

    assign head_data_o = data_q[rd_ptr_q];
    assign head_last_o = last_q[rd_ptr_q];
    assign occ_o       = occ_q;
    assign empty_o     = (occ_q == 2'd0);

endmodule

// File: rtl/v_ram_reader.sv
// Burst read engine for v_ram: issues addresses, captures words one cycle later,
// and streams them out with backpressure. Macro V_RAM_READER_STRIDE_EN adds a stride input.
module v_ram_reader
    import v_ram_pkg::*;
#(
    parameter int D_WIDTH = V_RAM_D_WIDTH,
    parameter int A_WIDTH = V_RAM_A_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [A_WIDTH-1:0] base_addr,
    input  logic [A_WIDTH:0]   len,
`ifdef V_RAM_READER_STRIDE_EN
    input  logic [A_WIDTH-1:0] stride,
`endif
    output logic               busy,
    output logic               done,
    output logic [A_WIDTH-1:0] r_addr,
    input  logic [D_WIDTH-1:0] ram_data,
    output logic [D_WIDTH-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output reader_state_t      dbg_state_o
);

    reader_state_t      state_q, state_d;
    logic [A_WIDTH-1:0] addr_q, addr_d;
    logic [A_WIDTH:0]   remain_q, remain_d;
    logic               zero_len_q, zero_len_d;
    logic               done_q, done_d;
    logic               inflight_q;
    logic               inflight_last_q;
    logic [A_WIDTH-1:0] step;

    logic               issue;
    logic               issue_last;
    logic               pop;
    logic [2:0]         pending;
    logic [D_WIDTH-1:0] head_data;
    logic               head_last;
    logic [1:0]         fifo_occ;
    logic               fifo_empty;

`ifdef V_RAM_READER_STRIDE_EN
    logic [A_WIDTH-1:0] stride_q, stride_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            stride_q <= '0;
        end else begin
            stride_q <= stride_d;
        end
    end

    assign step = stride_q;
`else
    assign step = A_WIDTH'(1);
`endif

    assign pop        = out_valid & out_ready;
    // Words already captured plus the one still inside the RAM pipeline.
    assign pending    = {1'b0, fifo_occ} + {2'b00, inflight_q};
    assign issue      = (state_q == ST_RUN) && (remain_q != '0) &&
                        (pending < (3'd2 + {2'b00, pop}));
    assign issue_last = issue && (remain_q == (A_WIDTH+1)'(1));

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        zero_len_d = zero_len_q;
        done_d     = 1'b0;
`ifdef V_RAM_READER_STRIDE_EN
        stride_d   = stride_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d     = base_addr;
                    remain_d   = len;
                    zero_len_d = (len == '0);
`ifdef V_RAM_READER_STRIDE_EN
                    stride_d   = stride;
`endif
                    state_d    = (len == '0) ? ST_DRAIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (issue) begin
                    addr_d   = addr_q + step;
                    remain_d = remain_q - (A_WIDTH+1)'(1);
                    if (issue_last) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (zero_len_q || (pop && head_last)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            addr_q          <= '0;
            remain_q        <= '0;
            zero_len_q      <= 1'b0;
            done_q          <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            remain_q        <= remain_d;
            zero_len_q      <= zero_len_d;
            done_q          <= done_d;
            inflight_q      <= issue;
            inflight_last_q <= issue_last;
        end
    end

    v_ram_skid_fifo #(
        .D_WIDTH(D_WIDTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (inflight_q),
        .push_data_i(ram_data),
        .push_last_i(inflight_last_q),
        .pop_i      (pop),
        .head_data_o(head_data),
        .head_last_o(head_last),
        .occ_o      (fifo_occ),
        .empty_o    (fifo_empty)
    );

    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign r_addr      = addr_q;
    assign out_valid   = ~fifo_empty;
    assign out_data    = head_data;
    assign out_last    = head_last & ~fifo_empty;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_v_ram_reader.sv
// Scoreboard bench for v_ram_reader with a behavioural registered-address RAM (mem[i]=i).
module tb_v_ram_reader;
  import v_ram_pkg::*;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int W  = DW + 1;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic [AW-1:0] stride;
  logic          busy;
  logic          done;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] ram_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  reader_state_t dbg_state;

  logic [DW-1:0] mem [16];
  logic [W-1:0]  exp_q[$];
  int            checks;
  int            failures;
  int            cyc;
  int            pops;
  int            done_seen;
  int            ready_mode;
  int            e0;
  int            dcyc;
  int            exp_dones;
  logic          stalled_prev;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  logic [W-1:0]  mon_e;

  v_ram_reader #(.D_WIDTH(DW), .A_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .len        (len),
`ifdef V_RAM_READER_STRIDE_EN
    .stride     (stride),
`endif
    .busy       (busy),
    .done       (done),
    .r_addr     (r_addr),
    .ram_data   (ram_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .dbg_state_o(dbg_state)
  );

  // clock/reset block and RAM model
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = DW'(i);
  end

  always @(posedge clk) ram_data <= mem[r_addr];
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = ~out_ready;
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      stalled_prev = 1'b0;
    end else begin
      if (stalled_prev && out_valid) begin
        check("stall_data_stable", 32'(out_data), 32'(prev_data));
        check("stall_last_stable", 32'(out_last), 32'(prev_last));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 32'(out_data), 32'hffff_ffff);
        end else begin
          mon_e = exp_q.pop_front();
          check("stream_data", 32'(out_data), 32'(mon_e[DW-1:0]));
          check("stream_last", 32'(out_last), 32'(mon_e[DW]));
        end
        pops++;
      end
      if (done) done_seen++;
      stalled_prev = out_valid && !out_ready;
      prev_data    = out_data;
      prev_last    = out_last;
    end
  end

  // driver tasks
  task automatic start_burst(input int b, input int l, input int s);
    for (int i = 0; i < l; i++) begin
      exp_q.push_back({(i == l - 1) ? 1'b1 : 1'b0, DW'((b + i * s) % 16)});
    end
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = AW'(b);
    len       = (AW+1)'(l);
    stride    = AW'(s);
    @(posedge clk);
    #1;
    e0    = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(output int dc);
    bit found;
    found = 1'b0;
    dc    = -1;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (done) begin
        found = 1'b1;
        dc    = cyc;
      end
    end
    if (!found) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_r_addr"}, 32'(r_addr), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_last"}, 32'(out_last), 32'd0);
    check({tag, "_out_data"}, 32'(out_data), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  initial begin
    int pops0;
    int dones0;
    bit got3;
    checks = 0; failures = 0; cyc = 0; pops = 0; done_seen = 0;
    ready_mode = 0; exp_dones = 0; stalled_prev = 1'b0;
    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; stride = AW'(1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // base=3 len=5: latency, data order, last, done timing
    start_burst(3, 5, 1);
    @(negedge clk);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_valid_e0", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("t1_valid_e1", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("t1_valid_e2", 32'(out_valid), 32'd1);
    check("t1_first_data", 32'(out_data), 32'd3);
    wait_done(dcyc);
    exp_dones++;
    check("t1_done_cycle", 32'(dcyc - e0), 32'd7);
    @(negedge clk);
    check("t1_done_pulse", 32'(done), 32'd0);
    check("t1_busy_end", 32'(busy), 32'd0);

    // address wrap, plus a start while busy that must be ignored
    start_burst(14, 4, 1);
    @(posedge clk);
    #1;
    start = 1'b1; base_addr = AW'(9); len = (AW+1)'(2);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(dcyc);
    exp_dones++;
    check("t2_done_cycle", 32'(dcyc - e0), 32'd6);

    // len=16: ready held low first (only 2 fetches), then toggling
    ready_mode = 2;
    repeat (2) @(posedge clk);
    start_burst(0, 16, 1);
    repeat (6) @(negedge clk);
    check("t3_bp_addr", 32'(r_addr), 32'd2);
    check("t3_bp_valid", 32'(out_valid), 32'd1);
    check("t3_bp_data", 32'(out_data), 32'd0);
    ready_mode = 1;
    wait_done(dcyc);
    exp_dones++;

    // len=0
    ready_mode = 0;
    repeat (2) @(posedge clk);
    start_burst(5, 0, 1);
    @(negedge clk);
    check("t4_busy", 32'(busy), 32'd1);
    check("t4_done_early", 32'(done), 32'd0);
    @(negedge clk);
    check("t4_done", 32'(done), 32'd1);
    check("t4_busy_end", 32'(busy), 32'd0);
    check("t4_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("t4_done_pulse", 32'(done), 32'd0);
    exp_dones++;

    // reset mid-burst after 3 words, then a fresh burst
    pops0 = pops;
    start_burst(8, 10, 1);
    got3 = 1'b0;
    for (int i = 0; i < 100 && !got3; i++) begin
      @(negedge clk);
      if (pops >= pops0 + 3) got3 = 1'b1;
    end
    if (!got3) check("t5_three_words_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_values("t5_midreset");
    exp_q.delete();
    dones0 = done_seen;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    check("t5_no_done", 32'(done_seen), 32'(dones0));
    start_burst(8, 10, 1);
    wait_done(dcyc);
    exp_dones++;
    check("t5_done_cycle", 32'(dcyc - e0), 32'd12);

`ifdef V_RAM_READER_STRIDE_EN
    start_burst(1, 4, 5);
    wait_done(dcyc);
    exp_dones++;
    check("t6_done_cycle", 32'(dcyc - e0), 32'd6);
`endif

    repeat (3) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_done_count", 32'(done_seen), 32'(exp_dones));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
